// File: rtl/xga_ball_pkg.sv
// Shared types and reset values for the multi-ball animator.
// Building with MULTI_BALL_COLLIDE_EN adds the COLLIDE state to the FSM enum.
package xga_ball_pkg;

  localparam int unsigned MAX_BALLS = 8;
  localparam int unsigned COORD_W   = 16;
  localparam int unsigned SPEED_W   = 3;

`ifdef MULTI_BALL_COLLIDE_EN
  typedef enum logic [1:0] {IDLE, STEP, COLLIDE, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, STEP, COMMIT} state_t;
`endif

  // dir_x/dir_y: 0 moves toward larger coordinates, 1 toward smaller
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SPEED_W-1:0] sx;
    logic [SPEED_W-1:0] sy;
    logic               dir_x;
    logic               dir_y;
  } ball_state_t;

  function automatic ball_state_t init_ball(input int unsigned i, input int unsigned n,
                                            input int unsigned w, input int unsigned h,
                                            input int unsigned ms);
    ball_state_t b;
    b.x     = COORD_W'((i + 1) * w / (n + 1));
    b.y     = COORD_W'(h / 2);
    b.sx    = SPEED_W'(1 + (i % ms));
    b.sy    = SPEED_W'(1 + (i % ms));
    b.dir_x = i[0];
    b.dir_y = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/ball_step.sv
// Combinational one-frame advance of a single ball with wall reflection on both axes.
module ball_step
  import xga_ball_pkg::*;
#(
  parameter int unsigned width       = 1024,
  parameter int unsigned height      = 768,
  parameter int unsigned ball_radius = 16
) (
  input  ball_state_t cur,
  output ball_state_t nxt
);

  // Two guard bits above the coordinate give headroom for the signed sum.
  localparam int unsigned AW = COORD_W + 2;
  localparam logic signed [AW-1:0] LO   = AW'(ball_radius);
  localparam logic signed [AW-1:0] HI_X = AW'(width - 1 - ball_radius);
  localparam logic signed [AW-1:0] HI_Y = AW'(height - 1 - ball_radius);

  logic signed [AW-1:0] nx;
  logic signed [AW-1:0] ny;

  // Low wall is tested first so it wins when a step would cross both.
  function automatic void reflect(input logic signed [AW-1:0] n, input logic signed [AW-1:0] hi,
                                  input logic dir, output logic [COORD_W-1:0] p,
                                  output logic d);
    if (n < LO) begin
      p = COORD_W'(LO);
      d = ~dir;
    end else if (n > hi) begin
      p = COORD_W'(hi);
      d = ~dir;
    end else begin
      p = COORD_W'(n);
      d = dir;
    end
  endfunction

  always_comb begin
    nxt = cur;
    nx  = signed'({2'b00, cur.x}) + (cur.dir_x ? -signed'(AW'(cur.sx)) : signed'(AW'(cur.sx)));
    ny  = signed'({2'b00, cur.y}) + (cur.dir_y ? -signed'(AW'(cur.sy)) : signed'(AW'(cur.sy)));
    reflect(nx, HI_X, cur.dir_x, nxt.x, nxt.dir_x);
    reflect(ny, HI_Y, cur.dir_y, nxt.y, nxt.dir_y);
  end

endmodule

// File: rtl/multi_ball_driver.sv
// Animates num_balls balls through one shared step datapath; positions publish atomically per frame.
// Define MULTI_BALL_COLLIDE_EN to add the pairwise velocity-swap COLLIDE pass.
module multi_ball_driver
  import xga_ball_pkg::*;
#(
  parameter int unsigned width       = 1024,
  parameter int unsigned height      = 768,
  parameter int unsigned num_balls   = 4,
  parameter int unsigned ball_radius = 16,
  parameter int unsigned max_speed   = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                move,
  input  logic                                pause,
  output logic [num_balls*$clog2(width)-1:0]  h_pos,
  output logic [num_balls*$clog2(height)-1:0] v_pos,
  output logic                                busy,
  output logic                                done,
  output logic                                overrun
);

  localparam int unsigned WX = $clog2(width);
  localparam int unsigned WY = $clog2(height);
  localparam int unsigned IW = (num_balls > 1) ? $clog2(num_balls) : 1;
  localparam logic [IW-1:0] LAST = IW'(num_balls - 1);

  ball_state_t     live   [num_balls];
  ball_state_t     shadow [num_balls];
  ball_state_t     stepped;
  state_t          state;
  logic [IW-1:0]   idx;

  ball_step #(
    .width      (width),
    .height     (height),
    .ball_radius(ball_radius)
  ) u_step (
    .cur(shadow[idx]),
    .nxt(stepped)
  );

`ifdef MULTI_BALL_COLLIDE_EN
  logic [IW-1:0]      pi;
  logic [IW-1:0]      pj;
  logic [COORD_W-1:0] ddx;
  logic [COORD_W-1:0] ddy;
  logic               hit;

  always_comb begin
    ddx = (shadow[pi].x > shadow[pj].x) ? shadow[pi].x - shadow[pj].x : shadow[pj].x - shadow[pi].x;
    ddy = (shadow[pi].y > shadow[pj].y) ? shadow[pi].y - shadow[pj].y : shadow[pj].y - shadow[pi].y;
    hit = (ddx < COORD_W'(2 * ball_radius)) && (ddy < COORD_W'(2 * ball_radius));
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      for (int unsigned i = 0; i < num_balls; i++) begin
        live[i]   <= init_ball(i, num_balls, width, height, max_speed);
        shadow[i] <= init_ball(i, num_balls, width, height, max_speed);
      end
`ifdef MULTI_BALL_COLLIDE_EN
      pi <= '0;
      pj <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (move && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (move) begin
            state <= STEP;
            idx   <= '0;
            busy  <= 1'b1;
            for (int unsigned i = 0; i < num_balls; i++) shadow[i] <= live[i];
          end
        end
        STEP: begin
          if (!pause) shadow[idx] <= stepped;
          if (idx == LAST) begin
            idx <= '0;
`ifdef MULTI_BALL_COLLIDE_EN
            if (num_balls > 1) begin
              state <= COLLIDE;
              pi    <= '0;
              pj    <= IW'(1);
            end else begin
              state <= COMMIT;
            end
`else
            state <= COMMIT;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
`ifdef MULTI_BALL_COLLIDE_EN
        // Pairs are scanned (0,1),(0,2)..(N-2,N-1); a swap is visible to later pairs.
        COLLIDE: begin
          if (hit && !pause) begin
            shadow[pi].sx    <= shadow[pj].sx;
            shadow[pi].sy    <= shadow[pj].sy;
            shadow[pi].dir_x <= shadow[pj].dir_x;
            shadow[pi].dir_y <= shadow[pj].dir_y;
            shadow[pj].sx    <= shadow[pi].sx;
            shadow[pj].sy    <= shadow[pi].sy;
            shadow[pj].dir_x <= shadow[pi].dir_x;
            shadow[pj].dir_y <= shadow[pi].dir_y;
          end
          if (pj == LAST) begin
            if (pi == LAST - 1'b1) begin
              state <= COMMIT;
            end else begin
              pi <= pi + 1'b1;
              pj <= pi + IW'(2);
            end
          end else begin
            pj <= pj + 1'b1;
          end
        end
`endif
        COMMIT: begin
          for (int unsigned i = 0; i < num_balls; i++) live[i] <= shadow[i];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    h_pos = '0;
    v_pos = '0;
    for (int unsigned i = 0; i < num_balls; i++) begin
      h_pos[i*WX +: WX] = live[i].x[WX-1:0];
      v_pos[i*WY +: WY] = live[i].y[WY-1:0];
    end
  end

endmodule

// File: tb/tb_multi_ball_driver.sv
// Directed and randomized frames against a behavioural ball model.
module tb_multi_ball_driver;

  localparam int W  = 1024;
  localparam int H  = 768;
  localparam int N  = 4;
  localparam int R  = 16;
  localparam int MS = 4;
  localparam int WX = $clog2(W);
  localparam int WY = $clog2(H);
`ifdef MULTI_BALL_COLLIDE_EN
  localparam int EXP_LAT = N + N * (N - 1) / 2 + 1;
`else
  localparam int EXP_LAT = N + 1;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            move = 1'b0;
  logic            pause = 1'b0;
  logic [N*WX-1:0] h_pos;
  logic [N*WY-1:0] v_pos;
  logic            busy;
  logic            done;
  logic            overrun;

  int errors = 0;
  int checks = 0;

  int mx [N];
  int my [N];
  int mvx[N];
  int mvy[N];
  bit movr;

  multi_ball_driver #(
    .width      (W),
    .height     (H),
    .num_balls  (N),
    .ball_radius(R),
    .max_speed  (MS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .move   (move),
    .pause  (pause),
    .h_pos  (h_pos),
    .v_pos  (v_pos),
    .busy   (busy),
    .done   (done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = (i + 1) * W / (N + 1);
      my[i]  = H / 2;
      mvx[i] = ((i % 2) == 0 ? 1 : -1) * (1 + i % MS);
      mvy[i] = 1 + i % MS;
    end
    movr = 1'b0;
  endfunction

  function automatic void axis(inout int p, inout int v, input int hi);
    int n;
    n = p + v;
    if (n < R) begin
      p = R;
      v = -v;
    end else if (n > hi) begin
      p = hi;
      v = -v;
    end else begin
      p = n;
    end
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic void model_frame(input bit p);
    int t;
    if (p) return;
    for (int i = 0; i < N; i++) begin
      axis(mx[i], mvx[i], W - 1 - R);
      axis(my[i], mvy[i], H - 1 - R);
    end
`ifdef MULTI_BALL_COLLIDE_EN
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (iabs(mx[i] - mx[j]) < 2 * R && iabs(my[i] - my[j]) < 2 * R) begin
          t = mvx[i]; mvx[i] = mvx[j]; mvx[j] = t;
          t = mvy[i]; mvy[i] = mvy[j]; mvy[j] = t;
        end
`else
    t = 0;
`endif
  endfunction

  task automatic check_pos(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", tag, i), 32'(h_pos[i*WX +: WX]), 32'(mx[i]));
      chk($sformatf("%s_y%0d", tag, i), 32'(v_pos[i*WY +: WY]), 32'(my[i]));
    end
  endtask

  // One frame; extra_at < 0 means no second move during the update.
  task automatic do_frame(input bit p, input int extra_at);
    int lat;
    pause = p;
    move  = 1'b1;
    tick();
    move = 1'b0;
    chk("busy_start", 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      check_pos("hold");
      if (lat == extra_at) begin
        move = 1'b1;
        movr = 1'b1;
      end
      tick();
      move = 1'b0;
      lat++;
    end
    model_frame(p);
    chk("latency", 32'(lat), 32'(EXP_LAT));
    check_pos("frame");
    chk("busy_end", 32'(busy), 32'd0);
    chk("overrun", 32'(overrun), 32'(movr));
    pause = 1'b0;
    tick();
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    model_reset();
    check_pos("rst");
    chk("rst_x0", 32'(h_pos[0 +: WX]), 32'd204);
    chk("rst_x3", 32'(h_pos[3*WX +: WX]), 32'd819);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    repeat (2) tick();

    do_frame(1'b0, -1);
`ifndef MULTI_BALL_COLLIDE_EN
    chk("first_x0", 32'(h_pos[0 +: WX]), 32'd205);
    chk("first_y1", 32'(v_pos[WY +: WY]), 32'd386);
`endif
    do_frame(1'b0, 1);
    do_frame(1'b1, -1);
    do_frame(1'b0, -1);

    for (int f = 0; f < 250; f++) begin
      do_frame($urandom_range(0, 3) == 0,
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, EXP_LAT - 1)) : -1);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset landing while ball 2 is being stepped.
    move = 1'b1;
    tick();
    move = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    check_pos("midrst");
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    for (int k = 0; k < EXP_LAT + 2; k++) begin
      tick();
      chk("midrst_nodone", 32'(done), 32'd0);
    end
    check_pos("midrst_hold");

    // Second move arriving in the commit cycle.
    do_frame(1'b0, EXP_LAT - 1);
    for (int f = 0; f < 20; f++) do_frame($urandom_range(0, 3) == 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_ball_driver.md
Name: multi_ball_driver

Overview:
Parametrised successor to the single-ball driver. Animates `num_balls` independent balls, each with its own speed, inside a width × height field with wall reflection. It time-multiplexes one shared step datapath across balls and publishes all positions atomically once per frame. It sits between the VGA driver's per-frame `refresh` strobe and the ball renderer(s).

Parameters:
- width, 1024, field width in pixels.
- height, 768, field height in pixels.
- num_balls, 4, number of balls; legal range 1..8.
- ball_radius, 16, radius in pixels; must satisfy 2*ball_radius < height.
- max_speed, 4, maximum per-axis step in pixels per frame; legal range 1..7.

Ports:
- clk, input, 1, system clock (75 MHz pixel clock).
- reset, input, 1, synchronous, active-low reset.
- move, input, 1, one-cycle pulse per frame that requests a position update.
- pause, input, 1, level signal; when high, updates complete but positions and vectors are frozen.
- h_pos, output, num_balls*log2(width), packed ball centre x coordinates; ball i occupies slice [i*log2(width) +: log2(width)].
- v_pos, output, num_balls*log2(height), packed ball centre y coordinates, packed the same way as h_pos.
- busy, output, 1, high while an update is in progress.
- done, output, 1, one-cycle pulse in the same cycle that h_pos and v_pos change.
- overrun, output, 1, sticky flag; set when `move` arrives while `busy` is high; cleared only by reset.

Behaviour:
- Reset (reset==0 at a clk edge), ball i:
  - x = (i+1)*width/(num_balls+1)
  - y = height/2
  - x direction = + for even i, − for odd i
  - y direction = + for all balls
  - speed_x = speed_y = 1 + (i mod max_speed)
  - busy=0, done=0, overrun=0; FSM goes to IDLE.
  - Reset has priority over every other input, including when it arrives mid-update. Shadow state is discarded.
- FSM states: IDLE, STEP, [COLLIDE], COMMIT.
  - IDLE: if move==1, go to STEP with idx=0 and busy=1.
  - STEP: one ball per cycle; idx counts 0..num_balls-1. The step result is written to shadow registers. After the last ball, go to COLLIDE (feature enabled) or COMMIT.
  - COMMIT: copy shadow to output registers, assert done for 1 cycle, clear busy, go to IDLE.
- Latency: move sampled at edge t produces done and the new positions at edge t+num_balls+1 (feature off).
- Step arithmetic is signed, log2(width)+2 bits wide. Per axis:
  - n = p + s·v.
  - If n < ball_radius: p = ball_radius and the sign flips.
  - If n > width-1-ball_radius (height-1-ball_radius on the y axis): p = that limit and the sign flips.
  - Otherwise p = n.
  - Only one reflection is applied per axis per step. If a step would cross both walls, the low wall wins.
- pause==1 sampled in STEP: the shadow copy keeps old values. COMMIT and done still occur.
- move while busy: ignored, and overrun is set. move in the same cycle as COMMIT is also ignored and sets overrun.
- Outputs never show a partially updated frame.

Optional Feature:
- Macro: MULTI_BALL_COLLIDE_EN.
- Defined:
  - After STEP, the COLLIDE state scans every pair (i<j) in lexicographic order, one pair per cycle, for num_balls*(num_balls-1)/2 cycles.
  - A pair collides when |xi−xj| < 2r and |yi−yj| < 2r. On collision, swap the full velocity vectors (sign and speed) of the two balls in shadow.
  - Positions are not corrected.
  - Latency becomes t+num_balls+P+1, where P is the pair count.
  - With num_balls==1, COLLIDE takes 0 cycles and is skipped.
- Undefined: the COLLIDE state and its logic are absent; balls pass through each other.

Decomposition:
- Package xga_ball_pkg holds:
  - the FSM state enum;
  - struct ball_state_t {x, y, sx, sy, dir_x, dir_y};
  - MAX_BALLS=8;
  - the reset-value function init_ball(i).
- log2 continues to come from const_funcs.h.
- One sub-module: ball_step. It is combinational and does the single-axis-pair update plus reflection for one ball. It is instantiated once and muxed by idx.

Test Plan:
- Reset with defaults → x={204,409,614,819}, y=384 for all, directions {+,−,+,−}/+, speeds {1,2,3,4}, busy=0, done=0, overrun=0.
- Single move pulse at cycle 10 → busy=1 on cycles 11–14, done=1 at cycle 15; ball0=(205,385), ball1=(407,386).
- Ball at x=1005, speed 4, direction + → after move, x=1007 and direction −; the next move gives x=1003.
- Second move while busy=1 → ignored, positions advance once, overrun=1 and stays set until reset=0.
- pause=1 with move → done pulses, positions and vectors unchanged; then pause=0 and move → normal step resumes.
- reset=0 asserted during STEP (idx=2) → next cycle all outputs equal reset values and done is never asserted. With MULTI_BALL_COLLIDE_EN, two balls placed 20 px apart → velocities swapped after one move.
